// File: rtl/lsu_mem_port_if.sv
// Pipeline and memory signal bundle for lsu_mem_port.
// slave: the LSU itself. master: the pipeline plus the data memory that surround it.
interface lsu_mem_port_if;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req, we, funct3, addr, wdata, mem_rdata,
    output ready, done, rdata, err, mem_addr, mem_read, mem_write, mem_wdata
  );

  modport master (
    output req, we, funct3, addr, wdata, mem_rdata,
    input  ready, done, rdata, err, mem_addr, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_port.sv
// RV32I load/store unit with a single-port word memory interface.
// Sub-word stores use a read-modify-write sequence.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/HU/W accesses fault instead of
// being silently aligned down.
module lsu_mem_port #(
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned SIZE      = 32
) (
  input logic         clk,
  input logic         rst,
  lsu_mem_port_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StLoad, StRmwRd, StStore, StDone} state_e;

  state_e          state;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [SIZE-1:0] wdata_q;

  logic       fault;
  logic [1:0] off;

  // Extract and extend the addressed byte/halfword from a memory word.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f3,
                                          input logic [1:0] o);
    logic [31:0] s;
    s = w >> {o, 3'b000};
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  // Replace the addressed byte/halfword of a memory word with store data.
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [2:0] f3,
                                        input logic [1:0] o, input logic [31:0] d);
    logic [31:0] mask;
    mask = (f3[1:0] == 2'b00) ? 32'h0000_00ff : 32'h0000_ffff;
    return (w & ~(mask << {o, 3'b000})) | ((d & mask) << {o, 3'b000});
  endfunction

  // Decode fault and effective byte offset of the incoming request.
  always_comb begin
    fault = 1'b0;
    off   = bus.addr[1:0];
    case (bus.funct3)
      3'b000: ;
      3'b100: fault = bus.we;
      3'b001, 3'b101: begin
`ifdef LSU_MISALIGN_TRAP_EN
        if (bus.addr[0]) fault = 1'b1;
`endif
        off = {bus.addr[1], 1'b0};
        if (bus.we && bus.funct3[2]) fault = 1'b1;
      end
      3'b010: begin
`ifdef LSU_MISALIGN_TRAP_EN
        if (bus.addr[1:0] != 2'b00) fault = 1'b1;
`endif
        off = 2'b00;
      end
      default: fault = 1'b1;
    endcase
    if ({2'b00, bus.addr[31:2]} >= 32'(MEM_WORDS)) fault = 1'b1;
  end

  // Access sequencer; every output is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= StIdle;
      we_q          <= 1'b0;
      f3_q          <= 3'b000;
      off_q         <= 2'b00;
      wdata_q       <= '0;
      bus.ready     <= 1'b1;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.rdata     <= 32'h0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr  <= 32'h0;
      bus.mem_wdata <= 32'h0;
    end else begin
      bus.done      <= 1'b0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      unique case (state)
        StIdle: begin
          if (bus.req) begin
            we_q          <= bus.we;
            f3_q          <= bus.funct3;
            off_q         <= off;
            wdata_q       <= bus.wdata;
            bus.ready     <= 1'b0;
            bus.mem_addr  <= {2'b00, bus.addr[31:2]};
            bus.mem_wdata <= bus.wdata;
            if (fault) begin
              state     <= StDone;
              bus.done  <= 1'b1;
              bus.err   <= 1'b1;
              bus.rdata <= 32'h0;
            end else if (!bus.we) begin
              state        <= StLoad;
              bus.mem_read <= 1'b1;
            end else if (bus.funct3 == 3'b010) begin
              state         <= StStore;
              bus.mem_write <= 1'b1;
            end else begin
              state        <= StRmwRd;
              bus.mem_read <= 1'b1;
            end
          end
        end
        StLoad: begin
          bus.rdata <= extract(bus.mem_rdata, f3_q, off_q);
          bus.done  <= 1'b1;
          state     <= StDone;
        end
        StRmwRd: begin
          bus.mem_wdata <= merge(bus.mem_rdata, f3_q, off_q, wdata_q);
          bus.mem_write <= 1'b1;
          state         <= StStore;
        end
        StStore: begin
          bus.done <= 1'b1;
          state    <= StDone;
        end
        StDone: begin
          bus.err   <= 1'b0;
          bus.ready <= 1'b1;
          state     <= StIdle;
        end
        default: begin
          bus.ready <= 1'b1;
          state     <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: directed cases, a reset-during-store case and
// randomized accesses against a byte-addressed reference memory.
module tb_lsu_mem_port;

  logic clk;
  logic rst;
  logic preload;

  lsu_mem_port_if bus ();

  lsu_mem_port #(
    .MEM_WORDS(256),
    .SIZE     (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [31:0] mem [256];
  logic [31:0] init_words [256];
  logic [7:0]  ref_bytes [1024];

  int vectors = 0;
  int fails   = 0;
  int rd_tot  = 0;
  int wr_tot  = 0;
  int both_tot = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr[7:0]] : 32'h0;

  // Data memory: commits writes on the falling edge.
  always @(negedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_words[i];
    end else if (bus.mem_write) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
  end

  // Count memory strobes for access-count checks.
  always @(negedge clk) begin
    if (bus.mem_read) rd_tot++;
    if (bus.mem_write) wr_tot++;
    if (bus.mem_read && bus.mem_write) both_tot++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_fault(input bit w, input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'd3 || f3 >= 3'd6) return 1'b1;
    if (w && f3 >= 3'd4) return 1'b1;
    if ((a >> 2) >= 32'd256) return 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if (f3[1:0] == 2'd1 && (a % 2) != 0) return 1'b1;
    if (f3 == 3'd2 && (a % 4) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_word(input int unsigned idx);
    return {ref_bytes[4*idx+3], ref_bytes[4*idx+2], ref_bytes[4*idx+1], ref_bytes[4*idx]};
  endfunction

  function automatic logic [31:0] ref_load(input int unsigned eff, input int nb, input bit sgn);
    logic [31:0] v;
    v = 32'h0;
    for (int k = 0; k < nb; k++) v = v | (32'(ref_bytes[eff + k]) << (8 * k));
    if (sgn && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
    return v;
  endfunction

  // One complete access; inputs driven and outputs sampled 1 time unit after posedge.
  task automatic access(input bit w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] got);
    bit          flt;
    int          nb;
    int unsigned eff;
    int          lat, exp_lat, exp_rd, exp_wr, rd0, wr0;
    logic [31:0] expv;
    flt     = is_fault(w, f3, a);
    nb      = 1 << f3[1:0];
    eff     = a - (a % nb);
    exp_lat = flt ? 1 : (!w ? 2 : (nb == 4 ? 2 : 3));
    exp_rd  = flt ? 0 : (!w ? 1 : (nb == 4 ? 0 : 1));
    exp_wr  = (!flt && w) ? 1 : 0;
    expv    = (!flt && !w) ? ref_load(eff, nb, !f3[2]) : 32'h0;
    check("ready_before", 32'(bus.ready), 32'd1);
    rd0 = rd_tot;
    wr0 = wr_tot;
    bus.req = 1'b1; bus.we = w; bus.funct3 = f3; bus.addr = a; bus.wdata = d;
    @(posedge clk); #1;
    // Request stays up with new contents; a busy LSU must ignore it.
    bus.we = 1'($urandom); bus.funct3 = 3'($urandom); bus.addr = $urandom;
    bus.wdata = $urandom;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    bus.req = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
    check("err", 32'(bus.err), 32'(flt));
    if (!w || flt) check("rdata", bus.rdata, expv);
    got = bus.rdata;
    check("mem_reads", 32'(rd_tot - rd0), 32'(exp_rd));
    check("mem_writes", 32'(wr_tot - wr0), 32'(exp_wr));
    if (!flt && w)
      for (int k = 0; k < nb; k++) ref_bytes[eff + k] = 8'(d >> (8 * k));
    @(posedge clk); #1;
    check("ready_after", 32'(bus.ready), 32'd1);
    check("err_cleared", 32'(bus.err), 32'd0);
    check("done_low", 32'(bus.done), 32'd0);
    if (!w || flt) check("rdata_hold", bus.rdata, expv);
    if ((a >> 2) < 32'd256) check("mem_word", mem[a[9:2]], ref_word(a >> 2));
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    int          done_seen;
    bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'b000; bus.addr = 32'h0; bus.wdata = 32'h0;
    rst = 1'b1;
    preload = 1'b1;
    for (int i = 0; i < 256; i++) begin
      init_words[i] = $urandom;
      for (int k = 0; k < 4; k++) ref_bytes[4*i+k] = 8'(init_words[i] >> (8 * k));
    end
    @(posedge clk); @(posedge clk); #1;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_mem_read", 32'(bus.mem_read), 32'd0);
    check("rst_mem_write", 32'(bus.mem_write), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    preload = 1'b0;
    rst = 1'b0;

    // Directed cases with literal expectations.
    access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, got);
    check("sw_word4", mem[4], 32'hDEADBEEF);
    access(1'b0, 3'b010, 32'h10, 32'h0, got);
    check("lw_deadbeef", got, 32'hDEADBEEF);
    access(1'b1, 3'b010, 32'h10, 32'h11223344, got);
    access(1'b1, 3'b000, 32'h11, 32'h000000A5, got);
    check("sb_merge", mem[4], 32'h1122A544);
    access(1'b0, 3'b000, 32'h11, 32'h0, got);
    check("lb_sext", got, 32'hFFFFFFA5);
    access(1'b0, 3'b100, 32'h11, 32'h0, got);
    check("lbu_zext", got, 32'h000000A5);
    access(1'b0, 3'b001, 32'h12, 32'h0, got);
    check("lh_hi", got, 32'h00001122);
    access(1'b0, 3'b010, 32'h400, 32'h0, got);
    check("lw_oob_rdata", got, 32'h0);
    access(1'b0, 3'b001, 32'h13, 32'h0, got);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lh_misalign", got, 32'h0);
`else
    check("lh_misalign", got, 32'h00001122);
`endif
    access(1'b1, 3'b001, 32'h16, 32'h0000BEEF, got);
    check("sh_merge", mem[5], {16'hBEEF, ref_bytes[21], ref_bytes[20]});
    access(1'b1, 3'b100, 32'h20, 32'h0, got);

    // Reset while a store is in its write cycle, before the committing negedge.
    bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'h24;
    bus.wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus.req = 1'b0;
    check("pre_rst_store", 32'(bus.mem_write), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_ready", 32'(bus.ready), 32'd1);
    check("midrst_mem_write", 32'(bus.mem_write), 32'd0);
    check("midrst_mem_addr", bus.mem_addr, 32'h0);
    check("midrst_mem_wdata", bus.mem_wdata, 32'h0);
    check("midrst_rdata", bus.rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.done === 1'b1) done_seen++;
      @(posedge clk); #1;
    end
    check("midrst_no_done", 32'(done_seen), 32'd0);
    check("midrst_mem_kept", mem[9], ref_word(9));
    check("midrst_ready_after", 32'(bus.ready), 32'd1);

    // Randomized accesses against the byte-level reference.
    for (int n = 0; n < 80; n++) begin
      a = $urandom_range(0, 1100);
      access(1'($urandom), 3'($urandom), a, $urandom, got);
    end

    check("never_read_and_write", 32'(both_tot), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/lsu_mem_port.md
LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Interface
REQ-001 Parameter MEM_WORDS, default 256, number of 32-bit words in the attached data memory.
REQ-002 Parameter SIZE, default 32, data word width; only 32 is supported.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  1  pipeline access request; sampled only while ready=1.
REQ-006 we  input  1  1=store, 0=load.
REQ-007 funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 addr  input  32  byte address.
REQ-009 wdata  input  32  store data, right-aligned.
REQ-010 ready  output  1  LSU idle; a request can be accepted.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 rdata  output  32  load result, extended; valid while done=1.
REQ-013 err  output  1  access fault, valid while done=1.
REQ-014 mem_addr  output  32  word index to memory (addr[31:2]).
REQ-015 mem_read  output  1  memory read enable; memory read data is combinational.
REQ-016 mem_write  output  1  memory write enable; memory commits on the negedge inside that cycle.
REQ-017 mem_wdata  output  32  full word to write.
REQ-018 mem_rdata  input  32  word returned by memory (zero when mem_read=0).

Function
REQ-019 FSM states IDLE, LOAD, RMW_RD, STORE, DONE; ready=1 only in IDLE.
REQ-020 IDLE: req=1 latches we, funct3, addr, wdata; load -> LOAD; SW -> STORE; SB/SH -> RMW_RD; fault -> DONE with err=1.
REQ-021 LOAD: mem_read=1 for one cycle, mem_rdata captured at posedge, -> DONE.
REQ-022 RMW_RD: mem_read=1 one cycle, word captured, -> STORE.
REQ-023 STORE: mem_write=1 one cycle, mem_wdata = SW: wdata; SB: captured word with byte addr[1:0] replaced by wdata[7:0]; SH: halfword addr[1] replaced by wdata[15:0]; -> DONE.
REQ-024 DONE: done=1 one cycle, -> IDLE; req is ignored in DONE.
REQ-025 Latency from accepting edge to done high: load 2 cycles, SW 2, SB/SH 3, fault 1.
REQ-026 Load extraction: byte/halfword selected by addr[1:0]/addr[1]; B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-027 mem_read and mem_write never high in the same cycle; both 0 outside LOAD/RMW_RD/STORE.
REQ-028 Faults: funct3 not legal for direction (011, 110, 111; stores also 100, 101) or addr[31:2] >= MEM_WORDS -> err=1, no memory access, rdata=0.
REQ-029 rdata holds last value after done; err cleared on leaving DONE.
REQ-030 mem_addr, mem_wdata driven from latched request, stable through access.

Reset
REQ-031 rst=1 forces IDLE immediately, ready=1, done=0, err=0, rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
REQ-032 rst mid-operation abandons the access; a STORE in progress does not write if rst rises before the negedge.
REQ-033 After rst deassert, a request is accepted on the first posedge.

Configuration
REQ-034 Macro LSU_MISALIGN_TRAP_EN: defined -> H/HU with addr[0]=1 or W with addr[1:0]!=0 is a fault per REQ-028.
REQ-035 Undefined -> offending low address bits are treated as 0 (natural alignment forced), no fault.

Verification
REQ-036 SW addr=0x10 wdata=0xDEADBEEF, then LW addr=0x10 -> mem word 4 = 0xDEADBEEF, rdata=0xDEADBEEF, done 2 cycles after each accept.
REQ-037 SB addr=0x11 wdata=0x000000A5 over word 0x11223344 -> word 0x1122A544, done after 3 cycles.
REQ-038 LB addr=0x11 on 0x1122A544 -> rdata=0xFFFFFFA5; LBU -> 0x000000A5; LH addr=0x12 -> 0x00001122.
REQ-039 LW addr=0x400 (MEM_WORDS=256) -> err=1, rdata=0, mem_read never high, done 1 cycle after accept.
REQ-040 LH addr=0x13: with LSU_MISALIGN_TRAP_EN err=1; without, rdata = sign-extended halfword at 0x12.
REQ-041 rst pulsed during STORE before negedge -> memory unchanged, ready=1 next cycle, done never asserted.
